// File: rtl/traffic_phase_controller.sv
// Round-robin N-approach traffic-light controller: demand-sensed green with
// min/max limits, yellow and all-red clearance, and a latched pedestrian walk.
module traffic_phase_controller #(
  parameter int NUM_DIR     = 2,
  parameter int TMR_W       = 8,
  parameter int GREEN_MIN   = 4,
  parameter int GREEN_MAX   = 8,
  parameter int YELLOW_TIME = 2,
  parameter int ALLRED_TIME = 1,
  parameter int WALK_TIME   = 3
) (
  input  logic               clka,
  input  logic               reseta,
  input  logic [NUM_DIR-1:0] car_sense,
  input  logic               ped_req,
  output logic [NUM_DIR-1:0] red,
  output logic [NUM_DIR-1:0] yellow,
  output logic [NUM_DIR-1:0] green,
  output logic               walk,
  output logic [1:0]         active_dir,
  output logic [TMR_W-1:0]   phase_timer
);

  typedef enum logic [1:0] {S_ALLRED, S_GREEN, S_YELLOW, S_WALK} state_e;

  localparam logic [TMR_W-1:0] AR_LAST   = TMR_W'(ALLRED_TIME - 1);
  localparam logic [TMR_W-1:0] GMIN_LAST = TMR_W'(GREEN_MIN - 1);
  localparam logic [TMR_W-1:0] GMAX_LAST = TMR_W'(GREEN_MAX - 1);
  localparam logic [TMR_W-1:0] Y_LAST    = TMR_W'(YELLOW_TIME - 1);
  localparam logic [TMR_W-1:0] W_LAST    = TMR_W'(WALK_TIME - 1);
  localparam logic [TMR_W-1:0] TMR_MAX   = '1;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [1:0]         dir_q, dir_d, next_dir;
  logic               ped_pend_q, ped_pend_d;
  logic               after_walk_q, after_walk_d;
  logic               first_q, first_d;
  logic [NUM_DIR-1:0] red_q, yellow_q, green_q;
  logic [NUM_DIR-1:0] red_d, yellow_d, green_d;
  logic               walk_q, walk_d;
  logic [NUM_DIR-1:0] own_mask;
  logic               own_car, other_dem;
  int                 cand;

  // Lamps are decoded from the next state so the registered outputs line up with it.
  generate
    for (genvar gi = 0; gi < NUM_DIR; gi++) begin : g_dir
      assign own_mask[gi] = (dir_q == 2'(gi));
      assign green_d[gi]  = (state_d == S_GREEN)  && (dir_d == 2'(gi));
      assign yellow_d[gi] = (state_d == S_YELLOW) && (dir_d == 2'(gi));
    end
  endgenerate

  assign red_d     = ~(green_d | yellow_d);
  assign walk_d    = (state_d == S_WALK);
  assign own_car   = |(car_sense & own_mask);
  assign other_dem = ped_pend_q | (|(car_sense & ~own_mask));

  // Scan from the farthest candidate down so the nearest demanding approach wins.
  always_comb begin
    cand     = 0;
    next_dir = (int'(dir_q) + 1 >= NUM_DIR) ? 2'd0 : dir_q + 2'd1;
    for (int k = NUM_DIR; k >= 1; k--) begin
      cand = int'(dir_q) + k;
      if (cand >= NUM_DIR) cand = cand - NUM_DIR;
      if (((car_sense >> cand) & NUM_DIR'(1)) != '0) next_dir = 2'(cand);
    end
  end

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    first_d      = first_q;
    ped_pend_d   = ped_pend_q | (ped_req && (state_q != S_WALK));
    after_walk_d = after_walk_q;
    case (state_q)
      S_ALLRED: begin
        if (timer_q == AR_LAST) begin
          after_walk_d = 1'b0;
          if (ped_pend_q && !after_walk_q) begin
            state_d    = S_WALK;
            ped_pend_d = 1'b0;
          end else begin
            state_d = S_GREEN;
            dir_d   = first_q ? 2'd0 : next_dir;
            first_d = 1'b0;
          end
        end
      end
      S_GREEN: begin
        // Once past max green, any conflicting demand ends the phase.
        if (timer_q >= GMIN_LAST && other_dem && (!own_car || timer_q >= GMAX_LAST))
          state_d = S_YELLOW;
      end
      S_YELLOW: begin
        if (timer_q == Y_LAST) state_d = S_ALLRED;
      end
      S_WALK: begin
        if (timer_q == W_LAST) begin
          state_d      = S_ALLRED;
          after_walk_d = 1'b1;
        end
      end
      default: state_d = S_ALLRED;
    endcase
    if (state_d != state_q) timer_d = '0;
    else if (timer_q == TMR_MAX) timer_d = timer_q;
    else timer_d = timer_q + 1'b1;
  end

  always_ff @(posedge clka) begin
    if (reseta) begin
      state_q      <= S_ALLRED;
      timer_q      <= '0;
      dir_q        <= 2'd0;
      ped_pend_q   <= 1'b0;
      after_walk_q <= 1'b0;
      first_q      <= 1'b1;
      red_q        <= '1;
      yellow_q     <= '0;
      green_q      <= '0;
      walk_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      dir_q        <= dir_d;
      ped_pend_q   <= ped_pend_d;
      after_walk_q <= after_walk_d;
      first_q      <= first_d;
      red_q        <= red_d;
      yellow_q     <= yellow_d;
      green_q      <= green_d;
      walk_q       <= walk_d;
    end
  end

  assign red         = red_q;
  assign yellow      = yellow_q;
  assign green       = green_q;
  assign walk        = walk_q;
  assign active_dir  = dir_q;
  assign phase_timer = timer_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Bench for traffic_phase_controller: directed scenarios plus randomized
// traffic checked against a phase-level behavioural model.
module tb_traffic_phase_controller;

  localparam int NUM_DIR     = 2;
  localparam int TMR_W       = 8;
  localparam int GREEN_MIN   = 4;
  localparam int GREEN_MAX   = 8;
  localparam int YELLOW_TIME = 2;
  localparam int ALLRED_TIME = 1;
  localparam int WALK_TIME   = 3;

  localparam int P_ALLRED = 0;
  localparam int P_GREEN  = 1;
  localparam int P_YELLOW = 2;
  localparam int P_WALK   = 3;

  logic               clka = 1'b0;
  logic               reseta;
  logic [NUM_DIR-1:0] car_sense;
  logic               ped_req;
  logic [NUM_DIR-1:0] red, yellow, green;
  logic               walk;
  logic [1:0]         active_dir;
  logic [TMR_W-1:0]   phase_timer;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: which phase, how long it has lasted, who is served, pending walk.
  int m_phase, m_age, m_dir;
  bit m_ped, m_after_walk, m_first;

  traffic_phase_controller #(
    .NUM_DIR(NUM_DIR), .TMR_W(TMR_W), .GREEN_MIN(GREEN_MIN), .GREEN_MAX(GREEN_MAX),
    .YELLOW_TIME(YELLOW_TIME), .ALLRED_TIME(ALLRED_TIME), .WALK_TIME(WALK_TIME)
  ) dut (
    .clka(clka), .reseta(reseta), .car_sense(car_sense), .ped_req(ped_req),
    .red(red), .yellow(yellow), .green(green), .walk(walk),
    .active_dir(active_dir), .phase_timer(phase_timer)
  );

  always #5 clka = ~clka;

  function automatic int pick_dir(input logic [1:0] car);
    for (int k = 1; k <= NUM_DIR; k++) begin
      int d = (m_dir + k) % NUM_DIR;
      if (((car >> d) & 2'b01) != 2'b00) return d;
    end
    return (m_dir + 1) % NUM_DIR;
  endfunction

  task automatic model_step(input bit rst, input logic [1:0] car, input bit ped);
    int nphase;
    bit others, own;
    if (rst) begin
      m_phase = P_ALLRED; m_age = 0; m_dir = 0;
      m_ped = 0; m_after_walk = 0; m_first = 1;
      return;
    end
    nphase = m_phase;
    own    = ((car >> m_dir) & 2'b01) != 2'b00;
    others = m_ped || ((car & ~(2'b01 << m_dir)) != 2'b00);
    case (m_phase)
      P_ALLRED: if (m_age == ALLRED_TIME - 1) begin
        if (m_ped && !m_after_walk) nphase = P_WALK;
        else begin
          nphase  = P_GREEN;
          m_dir   = m_first ? 0 : pick_dir(car);
          m_first = 0;
        end
      end
      P_GREEN:  if (m_age >= GREEN_MIN - 1 && others && (!own || m_age >= GREEN_MAX - 1))
                  nphase = P_YELLOW;
      P_YELLOW: if (m_age == YELLOW_TIME - 1) nphase = P_ALLRED;
      default:  if (m_age == WALK_TIME - 1) nphase = P_ALLRED;
    endcase
    if (ped && m_phase != P_WALK) m_ped = 1;
    if (nphase == P_WALK) m_ped = 0;
    if (nphase != m_phase) begin
      m_after_walk = (m_phase == P_WALK);
      m_age = 0;
    end else m_age++;
    m_phase = nphase;
  endtask

  function automatic logic [16:0] exp_vec();
    logic [1:0] g, y, one;
    logic [7:0] t;
    one = 2'(1 << m_dir);
    g = (m_phase == P_GREEN)  ? one : 2'b00;
    y = (m_phase == P_YELLOW) ? one : 2'b00;
    t = (m_age > 255) ? 8'hFF : 8'(m_age);
    return {~(g | y), y, g, (m_phase == P_WALK), 2'(m_dir), t};
  endfunction

  function automatic logic [16:0] got_vec();
    return {red, yellow, green, walk, active_dir, phase_timer};
  endfunction

  task automatic tick();
    @(posedge clka);
    model_step(reseta, car_sense, ped_req);
    #1;
  endtask

  task automatic do_reset();
    reseta = 1'b1; car_sense = '0; ped_req = 1'b0;
    tick(); tick();
    reseta = 1'b0;
  endtask

  task automatic test_reset();
    reseta = 1'b1; car_sense = 2'b11; ped_req = 1'b1;
    tick(); tick();
    n_checks++; if (red !== 2'b11) begin n_fail++; $display("FAIL reset_red got=%b exp=11", red); end
    n_checks++; if (green !== 2'b00) begin n_fail++; $display("FAIL reset_green got=%b exp=00", green); end
    n_checks++; if (yellow !== 2'b00) begin n_fail++; $display("FAIL reset_yellow got=%b exp=00", yellow); end
    n_checks++; if (walk !== 1'b0) begin n_fail++; $display("FAIL reset_walk got=%b exp=0", walk); end
    n_checks++; if (active_dir !== 2'd0) begin n_fail++; $display("FAIL reset_dir got=%0d exp=0", active_dir); end
    n_checks++; if (phase_timer !== 8'd0) begin n_fail++; $display("FAIL reset_timer got=%0d exp=0", phase_timer); end
    // The button pressed during reset must not survive it: the first green should rest.
    reseta = 1'b0; ped_req = 1'b0; car_sense = 2'b00;
    for (int c = 1; c <= 12; c++) begin
      tick();
      n_checks++;
      if (got_vec() !== exp_vec()) begin n_fail++; $display("FAIL reset_release c=%0d got=%h exp=%h", c, got_vec(), exp_vec()); end
    end
    $display("test_reset done checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  task automatic test_rest_in_green();
    bit saw_yellow = 0;
    do_reset();
    for (int c = 1; c <= 300; c++) begin
      tick();
      if (yellow !== 2'b00) saw_yellow = 1;
      n_checks++;
      if (got_vec() !== exp_vec()) begin n_fail++; $display("FAIL rest_model c=%0d got=%h exp=%h", c, got_vec(), exp_vec()); end
      if (c == 1) begin
        n_checks++; if (green !== 2'b01) begin n_fail++; $display("FAIL rest_first_green got=%b exp=01", green); end
      end
    end
    n_checks++; if (phase_timer !== 8'd255) begin n_fail++; $display("FAIL rest_saturate got=%0d exp=255", phase_timer); end
    n_checks++; if (saw_yellow) begin n_fail++; $display("FAIL rest_no_yellow got=1 exp=0"); end
    // Demand arriving after a long rest must end the green promptly.
    car_sense = 2'b10;
    for (int c = 1; c <= 8; c++) begin
      tick();
      n_checks++;
      if (got_vec() !== exp_vec()) begin n_fail++; $display("FAIL rest_leave c=%0d got=%h exp=%h", c, got_vec(), exp_vec()); end
    end
    n_checks++; if (green !== 2'b10) begin n_fail++; $display("FAIL rest_leave_green got=%b exp=10", green); end
    $display("test_rest_in_green done checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  task automatic test_gap_out();
    logic [1:0] eg, ey;
    do_reset();
    car_sense = 2'b10;
    for (int c = 1; c <= 14; c++) begin
      tick();
      eg = (c <= 4) ? 2'b01 : (c >= 8) ? 2'b10 : 2'b00;
      ey = (c == 5 || c == 6) ? 2'b01 : 2'b00;
      n_checks++;
      if ({green, yellow, red} !== {eg, ey, ~(eg | ey)}) begin
        n_fail++; $display("FAIL gap_lamps c=%0d got=%b_%b_%b exp=%b_%b_%b", c, green, yellow, red, eg, ey, ~(eg | ey));
      end
      n_checks++;
      if (got_vec() !== exp_vec()) begin n_fail++; $display("FAIL gap_model c=%0d got=%h exp=%h", c, got_vec(), exp_vec()); end
    end
    n_checks++; if (active_dir !== 2'd1) begin n_fail++; $display("FAIL gap_dir got=%0d exp=1", active_dir); end
    $display("test_gap_out done checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  task automatic test_max_out();
    int g0 = 0, g1 = 0, y0 = 0;
    do_reset();
    car_sense = 2'b11;
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (c <= 11 && green == 2'b01) g0++;
      if (c <= 11 && yellow == 2'b01) y0++;
      if (c >= 12 && c <= 22 && green == 2'b10) g1++;
      n_checks++;
      if (got_vec() !== exp_vec()) begin n_fail++; $display("FAIL max_model c=%0d got=%h exp=%h", c, got_vec(), exp_vec()); end
    end
    n_checks++; if (g0 != GREEN_MAX) begin n_fail++; $display("FAIL max_green0_len got=%0d exp=%0d", g0, GREEN_MAX); end
    n_checks++; if (y0 != YELLOW_TIME) begin n_fail++; $display("FAIL max_yellow_len got=%0d exp=%0d", y0, YELLOW_TIME); end
    n_checks++; if (g1 != GREEN_MAX) begin n_fail++; $display("FAIL max_green1_len got=%0d exp=%0d", g1, GREEN_MAX); end
    $display("test_max_out done checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  task automatic test_pedestrian();
    logic [1:0] eg, ey;
    logic       ew;
    do_reset();
    car_sense = 2'b00;
    for (int c = 1; c <= 18; c++) begin
      ped_req = (c == 2 || c == 9);
      tick();
      eg = (c <= 4) ? 2'b01 : (c >= 12) ? 2'b10 : 2'b00;
      ey = (c == 5 || c == 6) ? 2'b01 : 2'b00;
      ew = (c >= 8 && c <= 10);
      n_checks++;
      if ({green, yellow, red, walk} !== {eg, ey, ~(eg | ey), ew}) begin
        n_fail++; $display("FAIL ped_lamps c=%0d got=%b_%b_%b_%b exp=%b_%b_%b_%b", c, green, yellow, red, walk, eg, ey, ~(eg | ey), ew);
      end
      n_checks++;
      if (got_vec() !== exp_vec()) begin n_fail++; $display("FAIL ped_model c=%0d got=%h exp=%h", c, got_vec(), exp_vec()); end
    end
    ped_req = 1'b0;
    $display("test_pedestrian done checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  task automatic test_reset_mid_yellow();
    do_reset();
    car_sense = 2'b10;
    for (int c = 1; c <= 5; c++) tick();
    n_checks++; if (yellow !== 2'b01) begin n_fail++; $display("FAIL midy_in_yellow got=%b exp=01", yellow); end
    reseta = 1'b1;
    tick();
    n_checks++;
    if ({red, yellow, green, phase_timer} !== {2'b11, 2'b00, 2'b00, 8'd0}) begin
      n_fail++; $display("FAIL midy_reset got=%b_%b_%b_%0d exp=11_00_00_0", red, yellow, green, phase_timer);
    end
    reseta = 1'b0;
    tick();
    n_checks++;
    if ({green, active_dir} !== {2'b01, 2'd0}) begin
      n_fail++; $display("FAIL midy_first_green got=%b/%0d exp=01/0", green, active_dir);
    end
    for (int c = 1; c <= 10; c++) begin
      tick();
      n_checks++;
      if (got_vec() !== exp_vec()) begin n_fail++; $display("FAIL midy_model c=%0d got=%h exp=%h", c, got_vec(), exp_vec()); end
    end
    $display("test_reset_mid_yellow done checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 1; c <= 3000; c++) begin
      if ($urandom_range(0, 5) == 0) car_sense = 2'($urandom);
      ped_req = ($urandom_range(0, 19) == 0);
      reseta  = ($urandom_range(0, 599) == 0);
      tick();
      n_checks++;
      if (got_vec() !== exp_vec()) begin n_fail++; $display("FAIL rand_model c=%0d got=%h exp=%h", c, got_vec(), exp_vec()); end
      n_checks++;
      if ($countones(~red) > 1 || (walk && red !== 2'b11)) begin
        n_fail++; $display("FAIL rand_invariant c=%0d got red=%b walk=%b exp=at most one non-red, all red in walk", c, red, walk);
      end
    end
    reseta = 1'b0; ped_req = 1'b0;
    $display("test_random done checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  initial begin
    reseta = 1'b1; car_sense = '0; ped_req = 1'b0;
    model_step(1'b1, 2'b00, 1'b0);
    test_reset();
    test_rest_in_green();
    test_gap_out();
    test_max_out();
    test_pedestrian();
    test_reset_mid_yellow();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
